// File: rtl/cdu_read_counter_if.sv
// Bundle of the CDU phase strobes, resolver requests and the AGC count handshake
// seen by cdu_read_counter; the counter sits on the master side.
interface cdu_read_counter_if #(
   parameter int WIDTH  = 16,
   parameter int PEND_W = 4
) ();
   logic              ISSI2H;
   logic              ISSI3H;
   logic              PS25KH;
   logic              CCDUZ;
   logic              inc_req;
   logic              dec_req;
   logic              agc_ack;
   logic              cnt_plus;
   logic              cnt_minus;
   logic [WIDTH-1:0]  angle;
   logic [PEND_W-1:0] pend;
   logic              overflow;

   modport master (
      input  ISSI2H, ISSI3H, PS25KH, CCDUZ, inc_req, dec_req, agc_ack,
      output cnt_plus, cnt_minus, angle, pend, overflow
   );

   modport slave (
      output ISSI2H, ISSI3H, PS25KH, CCDUZ, inc_req, dec_req, agc_ack,
      input  cnt_plus, cnt_minus, angle, pend, overflow
   );
endinterface

// File: rtl/cdu_read_counter.sv
// Resolver angle counter fed by CDU phase strobes; forwards each count to the AGC
// as a plus/minus request with acknowledge, keeping a saturating signed backlog.
module cdu_read_counter #(
   parameter int WIDTH  = 16,
   parameter int PEND_W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   cdu_read_counter_if.master  bus
);

   typedef enum logic [1:0] {IDLE, DRV_P, DRV_M} state_e;

   localparam logic signed [PEND_W+1:0] POS_LIM = (PEND_W+2)'((1 << (PEND_W-1)) - 1);
   localparam logic signed [PEND_W+1:0] NEG_LIM = -POS_LIM;

   state_e                     state_q, state_d;
   logic                       req_p_q, req_p_d;
   logic                       req_m_q, req_m_d;
   logic [WIDTH-1:0]           angle_q, angle_d;
   logic signed [PEND_W-1:0]   pend_q, pend_d;
   logic                       overflow_q, overflow_d;
   logic                       cnt_plus_q, cnt_plus_d;
   logic                       cnt_minus_q, cnt_minus_d;

   logic signed [1:0]          delta;
   logic signed [1:0]          ackdir;
   logic signed [PEND_W+1:0]   pend_w, delta_w, ackdir_w, pend_sum;

   always_comb begin
      delta = 2'sb00;
      if (bus.ISSI3H) begin
         if (req_p_q)      delta = 2'sb01;
         else if (req_m_q) delta = 2'sb11;
      end

      // The ack direction is the one committed at issue, whatever pend has become since.
      ackdir = 2'sb00;
      if (bus.agc_ack && state_q == DRV_P)      ackdir = 2'sb01;
      else if (bus.agc_ack && state_q == DRV_M) ackdir = 2'sb11;

      pend_w   = pend_q;
      delta_w  = delta;
      ackdir_w = ackdir;
      pend_sum = pend_w + delta_w - ackdir_w;

      overflow_d = overflow_q;
      if (pend_sum > POS_LIM) begin
         pend_d     = POS_LIM[PEND_W-1:0];
         overflow_d = 1'b1;
      end else if (pend_sum < NEG_LIM) begin
         pend_d     = NEG_LIM[PEND_W-1:0];
         overflow_d = 1'b1;
      end else begin
         pend_d     = pend_sum[PEND_W-1:0];
      end

      angle_d = angle_q + WIDTH'(delta_w);

      req_p_d = req_p_q;
      req_m_d = req_m_q;
      if (bus.ISSI3H) begin
         req_p_d = 1'b0;
         req_m_d = 1'b0;
      end
      if (bus.ISSI2H) begin
         req_p_d = bus.inc_req & ~bus.dec_req;
         req_m_d = bus.dec_req & ~bus.inc_req;
      end

      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.PS25KH && !pend_q[PEND_W-1] && pend_q != '0) state_d = DRV_P;
            else if (bus.PS25KH && pend_q[PEND_W-1])             state_d = DRV_M;
         end
         DRV_P, DRV_M: begin
            if (bus.agc_ack) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (bus.CCDUZ) begin
         state_d    = IDLE;
         req_p_d    = 1'b0;
         req_m_d    = 1'b0;
         angle_d    = '0;
         pend_d     = '0;
         overflow_d = 1'b0;
      end

      cnt_plus_d  = (state_d == DRV_P);
      cnt_minus_d = (state_d == DRV_M);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         req_p_q     <= 1'b0;
         req_m_q     <= 1'b0;
         angle_q     <= '0;
         pend_q      <= '0;
         overflow_q  <= 1'b0;
         cnt_plus_q  <= 1'b0;
         cnt_minus_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_p_q     <= req_p_d;
         req_m_q     <= req_m_d;
         angle_q     <= angle_d;
         pend_q      <= pend_d;
         overflow_q  <= overflow_d;
         cnt_plus_q  <= cnt_plus_d;
         cnt_minus_q <= cnt_minus_d;
      end
   end

   assign bus.cnt_plus  = cnt_plus_q;
   assign bus.cnt_minus = cnt_minus_q;
   assign bus.angle     = angle_q;
   assign bus.pend      = pend_q;
   assign bus.overflow  = overflow_q;

endmodule
